// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - tap table, mode and state encodings for the LFSR down-counter
package lfsr_pkg;

  typedef enum logic [1:0] {
    MODE_ONE_SHOT    = 2'b00,
    MODE_AUTO_RELOAD = 2'b01,
    MODE_FREE_RUN    = 2'b10,
    MODE_FREE_RUN_2  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam int unsigned MIN_WIDTH = 4;
  localparam int unsigned MAX_WIDTH = 16;

  // Bit k-1 set for each tap k; every set has an even tap count, so XNOR
  // feedback reduces to inverted parity and all-ones is the lockup state.
  function automatic logic [15:0] tap_mask(input int unsigned width);
    case (width)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - one combinational XNOR Fibonacci LFSR step
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] next
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(tap_mask(WIDTH));

  generate
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("lfsr_step: WIDTH must be within 4..16");
    end
  endgenerate

  logic fb;

  assign fb   = ~^(count & TAPS);
  assign next = {count[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_dcnto_gen.sv
// rtl/lfsr_dcnto_gen.sv - LFSR counter with terminal compare, one-shot/reload/free-run modes
module lfsr_dcnto_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cen,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] count_to,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tercnt,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  generate
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("lfsr_dcnto_gen: WIDTH must be within 4..16");
    end
  endgenerate

  state_e           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] data_safe;
  logic             data_bad;
  logic             done_n;
  logic             err_n;

  lfsr_step #(.WIDTH(WIDTH)) u_step (
    .count (count),
    .next  (step_next)
  );

  // The lockup value is never allowed into the register; it loads as zero.
  assign data_bad  = (data == ALL_ONES);
  assign data_safe = data_bad ? '0 : data;

  assign tercnt = (state == ST_RUN) && (count == count_to) && (count_to != ALL_ONES);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      count <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    done_n  = done;
    err_n   = 1'b0;
    if (load) begin
      state_n = ST_RUN;
      count_n = data_safe;
      done_n  = 1'b0;
      err_n   = data_bad;
    end else if (cen && state == ST_RUN) begin
      if (tercnt) begin
        case (mode)
          MODE_ONE_SHOT: begin
            state_n = ST_HALT;
            done_n  = 1'b1;
          end
          MODE_AUTO_RELOAD: begin
            count_n = data_safe;
            err_n   = data_bad;
          end
          default: count_n = step_next;
        endcase
      end else begin
        count_n = step_next;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_dcnto_gen.sv
// tb/tb_lfsr_dcnto_gen.sv - directed self-checking bench for lfsr_dcnto_gen at WIDTH=4
module tb_lfsr_dcnto_gen;

  logic       clk;
  logic       reset;
  logic       cen;
  logic       load;
  logic [3:0] data;
  logic [3:0] count_to;
  logic [1:0] mode;
  logic [3:0] count;
  logic       tercnt;
  logic       done;
  logic       err;

  int n_asserts;
  int n_fail;

  lfsr_dcnto_gen #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .cen      (cen),
    .load     (load),
    .data     (data),
    .count_to (count_to),
    .mode     (mode),
    .count    (count),
    .tercnt   (tercnt),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] seq [15];
  logic [3:0] reload_seq [8];
  logic       seen_ter;
  logic       seen_err;

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    seq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
            4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};
    reload_seq = '{4'h7, 4'hE, 4'hD, 4'h3, 4'h7, 4'hE, 4'hD, 4'h3};

    reset = 1'b1; cen = 1'b0; load = 1'b0; data = 4'h0; count_to = 4'hF; mode = 2'b10;
    step();
    check("reset_count", count, 4'h0);
    check("reset_done", {3'b0, done}, 4'h0);
    check("reset_err", {3'b0, err}, 4'h0);
    check("reset_tercnt", {3'b0, tercnt}, 4'h0);

    // Free-run full period
    reset = 1'b0; cen = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      check($sformatf("freerun_%0d", i), count, seq[i % 15]);
    end

    // One-shot to 0111
    reset = 1'b1; cen = 1'b0; count_to = 4'h7;
    step();
    reset = 1'b0; mode = 2'b00; cen = 1'b1;
    step(); check("os_e1", count, 4'h1); check("os_e1_ter", {3'b0, tercnt}, 4'h0);
    step(); check("os_e2", count, 4'h3);
    step(); check("os_e3", count, 4'h7); check("os_e3_ter", {3'b0, tercnt}, 4'h1);
    step(); check("os_halt_count", count, 4'h7); check("os_halt_done", {3'b0, done}, 4'h1);
    check("os_halt_ter", {3'b0, tercnt}, 4'h0);
    step(); check("os_hold_count", count, 4'h7); check("os_hold_done", {3'b0, done}, 4'h1);
    load = 1'b1; data = 4'h1;
    step(); check("os_reload_count", count, 4'h1); check("os_reload_done", {3'b0, done}, 4'h0);
    load = 1'b0;
    step(); check("os_resume", count, 4'h3);

    // Auto-reload 0011 -> 1101
    mode = 2'b01; load = 1'b1; data = 4'h3; count_to = 4'hD; cen = 1'b1;
    step(); check("ar_load", count, 4'h3);
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("ar_count_%0d", i), count, reload_seq[i]);
      check($sformatf("ar_ter_%0d", i), {3'b0, tercnt}, (reload_seq[i] == 4'hD) ? 4'h1 : 4'h0);
    end

    // Auto-reload with an illegal reload value
    load = 1'b1; data = 4'h0; count_to = 4'h1;
    step(); check("arbad_load", count, 4'h0);
    load = 1'b0; data = 4'hF;
    step(); check("arbad_c1", count, 4'h1); check("arbad_ter", {3'b0, tercnt}, 4'h1);
    step(); check("arbad_reload", count, 4'h0); check("arbad_err", {3'b0, err}, 4'h1);
    step(); check("arbad_next", count, 4'h1); check("arbad_err_clr", {3'b0, err}, 4'h0);

    // Illegal load value, then all-ones terminal never matches
    load = 1'b1; data = 4'hF; cen = 1'b0;
    step(); check("bad_load_count", count, 4'h0); check("bad_load_err", {3'b0, err}, 4'h1);
    load = 1'b0;
    step(); check("bad_load_err_pulse", {3'b0, err}, 4'h0); check("bad_load_hold", count, 4'h0);
    mode = 2'b10; count_to = 4'hF; cen = 1'b1;
    seen_ter = 1'b0; seen_err = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      seen_ter |= tercnt;
      seen_err |= err | (count == 4'hF);
    end
    check("ones_never_ter", {3'b0, seen_ter}, 4'h0);
    check("ones_never_err", {3'b0, seen_err}, 4'h0);

    // Load beats cen; reset beats load in HALT
    load = 1'b1; cen = 1'b1; data = 4'hA;
    step(); check("load_wins", count, 4'hA);
    load = 1'b0; mode = 2'b00; count_to = 4'hA;
    #1; check("pre_halt_ter", {3'b0, tercnt}, 4'h1);
    step(); check("halt_count", count, 4'hA); check("halt_done", {3'b0, done}, 4'h1);
    mode = 2'b10;
    step(); check("halt_ignores_mode", count, 4'hA); check("halt_ter", {3'b0, tercnt}, 4'h0);
    reset = 1'b1; load = 1'b1; data = 4'h5;
    step(); check("rst_over_load_count", count, 4'h0); check("rst_over_load_done", {3'b0, done}, 4'h0);
    reset = 1'b0; load = 1'b0;

    // Hold with cen=0 at 0110
    load = 1'b1; data = 4'h6; cen = 1'b0; count_to = 4'h6; mode = 2'b00;
    step(); check("hold_load", count, 4'h6);
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold_count_%0d", i), count, 4'h6);
      check($sformatf("hold_done_%0d", i), {3'b0, done}, 4'h0);
      check($sformatf("hold_ter_%0d", i), {3'b0, tercnt}, 4'h1);
    end
    cen = 1'b1;
    step(); check("hold_release_done", {3'b0, done}, 4'h1); check("hold_release_count", count, 4'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
